fm_tune_ctrl: RTL and testbench

Button-driven tuning controller for the FM transmitter carrier. It debounces the five board keys, turns presses into fine and coarse frequency steps inside the broadcast band, and schedules each retune. Every retune is wrapped in a mute window so the audio path can silence itself around the carrier jump. It sits between the raw key inputs and the `fmgen` `cw_freq` input, in the 25 MHz system clock domain.

---
 rtl/fm_tune_pkg.sv | 66 ++++++
 rtl/btn_debounce.sv | 95 +++++++++
 rtl/fm_tune_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fm_tune_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_tune_pkg.sv
// rtl/fm_tune_pkg.sv - shared types, constants and retune arithmetic for fm_tune_ctrl
// Contents: event enum, FSM state enum, key indices, band/step/timing defaults,
//           next_freq() helper. Macro FM_TUNE_AUTOREPEAT_EN adds repeat-timer defaults.
package fm_tune_pkg;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CENTER,
        EV_UP,
        EV_DOWN,
        EV_RIGHT,
        EV_LEFT
    } ev_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUTE_PRE,
        ST_APPLY,
        ST_MUTE_POST
    } state_t;

    localparam int unsigned DEBOUNCE_CYCLES     = 500000;
    localparam int unsigned MUTE_CYCLES         = 250000;
`ifdef FM_TUNE_AUTOREPEAT_EN
    localparam int unsigned REPEAT_DELAY_CYCLES = 12500000;
    localparam int unsigned REPEAT_RATE_CYCLES  = 2500000;
`endif
    localparam int unsigned FREQ_MIN            = 87500000;
    localparam int unsigned FREQ_MAX            = 108000000;
    localparam int unsigned FREQ_DEFAULT        = 104000000;
    localparam int unsigned STEP_FINE           = 50000;
    localparam int unsigned STEP_COARSE         = 1000000;

    // Bit positions of the keys in the internal key vector
    localparam int K_UP     = 0;
    localparam int K_DOWN   = 1;
    localparam int K_RIGHT  = 2;
    localparam int K_LEFT   = 3;
    localparam int K_CENTER = 4;

    // Wrapping band arithmetic; 33-bit intermediates so the sum cannot overflow
    function automatic logic [31:0] next_freq(
        input ev_t         ev,
        input logic [31:0] cur,
        input logic [31:0] fmin,
        input logic [31:0] fmax,
        input logic [31:0] fdef,
        input logic [31:0] fine,
        input logic [31:0] coarse
    );
        logic [32:0] step;
        logic [32:0] sum;
        logic [31:0] res;
        step = {1'b0, ((ev == EV_UP) || (ev == EV_DOWN)) ? fine : coarse};
        sum  = {1'b0, cur} + step;
        case (ev)
            EV_CENTER:        res = fdef;
            EV_UP, EV_RIGHT:  res = (sum > {1'b0, fmax}) ? fmin : sum[31:0];
            EV_DOWN, EV_LEFT: res = ({1'b0, cur} < ({1'b0, fmin} + step)) ? fmax
                                                                         : (cur - step[31:0]);
            default:          res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - key synchronizer, debouncer and press pulse
// Ports: clk, rst_n (async active-low), key_i raw key, press_o one-cycle pulse on a
//        debounced rising edge; with FM_TUNE_AUTOREPEAT_EN also repeat_o auto-repeat pulse.
module btn_debounce
    import fm_tune_pkg::*;
#(
    parameter int unsigned C_DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES
`ifdef FM_TUNE_AUTOREPEAT_EN
   ,parameter int unsigned C_REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES,
    parameter int unsigned C_REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES,
    parameter bit          G_REPEAT_EN           = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
`ifdef FM_TUNE_AUTOREPEAT_EN
   ,output logic repeat_o
`endif
);

    localparam int DW = $clog2(C_DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(C_DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          press_q;
    logic [DW-1:0] cnt_q;

    // Counter runs only while the synchronized input disagrees with the accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            press_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                level_q <= sync_q[1];
                press_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + DW'(1);
            end
        end
    end

    assign press_o = press_q;

`ifdef FM_TUNE_AUTOREPEAT_EN
    localparam int unsigned RMAX = (C_REPEAT_DELAY_CYCLES > C_REPEAT_RATE_CYCLES) ?
                                   C_REPEAT_DELAY_CYCLES : C_REPEAT_RATE_CYCLES;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(C_REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(C_REPEAT_RATE_CYCLES - 1);

    logic [RW-1:0] rcnt_q;
    logic          armed_q;
    logic          rep_q;

    // The counter is zero in the press cycle, so the first repeat lands exactly
    // one delay after the press; armed_q switches to the shorter repeat period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q  <= '0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
        end else if (!level_q) begin
            rcnt_q  <= '0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            rep_q <= 1'b0;
            if (!armed_q && (rcnt_q == DELAY_LAST)) begin
                rep_q   <= 1'b1;
                armed_q <= 1'b1;
                rcnt_q  <= '0;
            end else if (armed_q && (rcnt_q == RATE_LAST)) begin
                rep_q  <= 1'b1;
                rcnt_q <= '0;
            end else begin
                rcnt_q <= rcnt_q + RW'(1);
            end
        end
    end

    assign repeat_o = rep_q & G_REPEAT_EN;
`endif

endmodule

// File: rtl/fm_tune_ctrl.sv
// rtl/fm_tune_ctrl.sv - key-driven FM carrier tuning controller with muted retune sequence
// Ports: clk, rst_n (async active-low), btn_up/down/left/right/center raw keys,
//        cw_freq carrier Hz, freq_upd change pulse, mute audio mute request, busy not-idle.
// Macro FM_TUNE_AUTOREPEAT_EN enables auto-repeat on the four direction keys.
module fm_tune_ctrl
    import fm_tune_pkg::*;
#(
    parameter int unsigned C_DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES,
    parameter int unsigned C_MUTE_CYCLES         = MUTE_CYCLES,
`ifdef FM_TUNE_AUTOREPEAT_EN
    parameter int unsigned C_REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES,
    parameter int unsigned C_REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES,
`endif
    parameter int unsigned C_FREQ_MIN            = FREQ_MIN,
    parameter int unsigned C_FREQ_MAX            = FREQ_MAX,
    parameter int unsigned C_FREQ_DEFAULT        = FREQ_DEFAULT,
    parameter int unsigned C_STEP_FINE           = STEP_FINE,
    parameter int unsigned C_STEP_COARSE         = STEP_COARSE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_center,
    output logic [31:0] cw_freq,
    output logic        freq_upd,
    output logic        mute,
    output logic        busy
);

    localparam int MW = $clog2(C_MUTE_CYCLES + 1);
    localparam logic [MW-1:0] MUTE_LAST = MW'(C_MUTE_CYCLES - 1);

    logic [4:0] key_raw;
    logic [4:0] key_ev;

    assign key_raw = {btn_center, btn_left, btn_right, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_key
        logic press;
`ifdef FM_TUNE_AUTOREPEAT_EN
        logic rpt;
        btn_debounce #(
            .C_DEBOUNCE_CYCLES    (C_DEBOUNCE_CYCLES),
            .C_REPEAT_DELAY_CYCLES(C_REPEAT_DELAY_CYCLES),
            .C_REPEAT_RATE_CYCLES (C_REPEAT_RATE_CYCLES),
            .G_REPEAT_EN          (i != K_CENTER)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_i   (key_raw[i]),
            .press_o (press),
            .repeat_o(rpt)
        );
        assign key_ev[i] = press | rpt;
`else
        btn_debounce #(
            .C_DEBOUNCE_CYCLES(C_DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_i  (key_raw[i]),
            .press_o(press)
        );
        assign key_ev[i] = press;
`endif
    end

    ev_t ev;

    always_comb begin
        ev = EV_NONE;
        if      (key_ev[K_CENTER]) ev = EV_CENTER;
        else if (key_ev[K_UP])     ev = EV_UP;
        else if (key_ev[K_DOWN])   ev = EV_DOWN;
        else if (key_ev[K_RIGHT])  ev = EV_RIGHT;
        else if (key_ev[K_LEFT])   ev = EV_LEFT;
    end

    state_t        state_q, state_d;
    ev_t           cur_q, cur_d;
    ev_t           pend_q, pend_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic [31:0]   freq_q, freq_d;
    logic          upd_q, upd_d;
    logic          mute_q, mute_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        mcnt_d  = mcnt_q;
        freq_d  = freq_q;
        upd_d   = 1'b0;

        // Events during a retune are held one deep, newest wins
        if ((state_q != ST_IDLE) && (ev != EV_NONE)) begin
            pend_d = ev;
        end

        case (state_q)
            ST_IDLE: begin
                if (ev != EV_NONE) begin
                    cur_d   = ev;
                    pend_d  = EV_NONE;
                    mcnt_d  = '0;
                    state_d = ST_MUTE_PRE;
                end else if (pend_q != EV_NONE) begin
                    cur_d   = pend_q;
                    pend_d  = EV_NONE;
                    mcnt_d  = '0;
                    state_d = ST_MUTE_PRE;
                end
            end
            ST_MUTE_PRE: begin
                if (mcnt_q == MUTE_LAST) begin
                    mcnt_d  = '0;
                    freq_d  = next_freq(cur_q, freq_q, C_FREQ_MIN, C_FREQ_MAX,
                                        C_FREQ_DEFAULT, C_STEP_FINE, C_STEP_COARSE);
                    upd_d   = 1'b1;
                    state_d = ST_APPLY;
                end else begin
                    mcnt_d = mcnt_q + MW'(1);
                end
            end
            ST_APPLY: begin
                state_d = ST_MUTE_POST;
            end
            ST_MUTE_POST: begin
                if (mcnt_q == MUTE_LAST) begin
                    mcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    mcnt_d = mcnt_q + MW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mute_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= EV_NONE;
            pend_q  <= EV_NONE;
            mcnt_q  <= '0;
            freq_q  <= C_FREQ_DEFAULT;
            upd_q   <= 1'b0;
            mute_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            mcnt_q  <= mcnt_d;
            freq_q  <= freq_d;
            upd_q   <= upd_d;
            mute_q  <= mute_d;
        end
    end

    assign cw_freq  = freq_q;
    assign freq_upd = upd_q;
    assign mute     = mute_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// tb/tb_fm_tune_ctrl.sv - self-checking bench for fm_tune_ctrl (FM_TUNE_AUTOREPEAT_EN aware)
module tb_fm_tune_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_center = 1'b0;
    logic [31:0] cw_freq;
    logic        freq_upd;
    logic        mute;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fm_tune_ctrl #(
        .C_DEBOUNCE_CYCLES    (4),
        .C_MUTE_CYCLES        (8)
`ifdef FM_TUNE_AUTOREPEAT_EN
       ,.C_REPEAT_DELAY_CYCLES(40),
        .C_REPEAT_RATE_CYCLES (10)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_center(btn_center),
        .cw_freq   (cw_freq),
        .freq_upd  (freq_upd),
        .mute      (mute),
        .busy      (busy)
    );

    // key vector order: {center, left, right, down, up}
    localparam logic [4:0] KU = 5'b00001;
    localparam logic [4:0] KD = 5'b00010;
    localparam logic [4:0] KR = 5'b00100;
    localparam logic [4:0] KL = 5'b01000;
    localparam logic [4:0] KC = 5'b10000;

    typedef struct {
        logic [4:0]  keys;
        int          reps;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_keys(input logic [4:0] k);
        {btn_center, btn_left, btn_right, btn_down, btn_up} = k;
    endtask

    // Press, release at mute start, and check the whole muted retune window
    task automatic press_once(input logic [4:0] k, input string name);
        int lat;
        int idx;
        int nupd;
        int upd_at;
        set_keys(k);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mute !== 1'b1 && lat < 40);
        set_keys(5'b0);
        check({name, " latency"}, lat, 7);
        check({name, " busy"}, {31'b0, busy}, 1);
        idx    = 0;
        nupd   = 0;
        upd_at = -1;
        while (mute === 1'b1 && idx < 60) begin
            if (freq_upd === 1'b1) begin
                nupd++;
                upd_at = idx;
            end
            @(negedge clk);
            idx++;
        end
        check({name, " mute_len"}, idx, 17);
        check({name, " upd_cnt"}, nupd, 1);
        check({name, " upd_pos"}, upd_at, 8);
        repeat (2) @(negedge clk);
        check({name, " idle_after"}, {30'b0, busy, mute}, 0);
    endtask

    initial begin
        int n;
        int lat;
        int nupd;

        vt[0]  = '{KU,      1,  32'd104050000, "up"};
        vt[1]  = '{KD,      1,  32'd104000000, "down"};
        vt[2]  = '{KR,      3,  32'd107000000, "right3"};
        vt[3]  = '{KU,      10, 32'd107500000, "up10"};
        vt[4]  = '{KR,      1,  32'd87500000,  "right_wrap"};
        vt[5]  = '{KD,      1,  32'd108000000, "down_wrap"};
        vt[6]  = '{KU,      1,  32'd87500000,  "up_wrap"};
        vt[7]  = '{KU,      10, 32'd88000000,  "up10_b"};
        vt[8]  = '{KL,      1,  32'd108000000, "left_wrap"};
        vt[9]  = '{KL,      1,  32'd107000000, "left"};
        vt[10] = '{KC,      1,  32'd104000000, "center"};
        vt[11] = '{KC,      1,  32'd104000000, "center_home"};
        vt[12] = '{KU | KL, 1,  32'd104050000, "up_left"};
        vt[13] = '{KC | KU | KD, 1, 32'd104000000, "center_up_down"};
        vt[14] = '{KD | KR, 1,  32'd103950000, "down_right"};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_freq", cw_freq, 32'd104000000);
        check("rst_flags", {29'b0, freq_upd, mute, busy}, 0);
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (mute !== 1'b0 || busy !== 1'b0 || freq_upd !== 1'b0) n++;
        end
        check("idle_quiet", n, 0);
        check("idle_freq", cw_freq, 32'd104000000);

        // Table of presses
        for (int i = 0; i < 15; i++) begin
            for (int r = 0; r < vt[i].reps; r++) press_once(vt[i].keys, vt[i].name);
            check({vt[i].name, " freq"}, cw_freq, vt[i].exp);
        end

        // Glitches of 1..3 cycles on down
        for (int g = 1; g <= 3; g++) begin
            set_keys(KD);
            repeat (g) @(negedge clk);
            set_keys(5'b0);
            n = 0;
            repeat (20) begin
                @(negedge clk);
                if (mute !== 1'b0 || busy !== 1'b0) n++;
            end
            check($sformatf("glitch%0d quiet", g), n, 0);
            check($sformatf("glitch%0d freq", g), cw_freq, 32'd103950000);
        end

        // Pending: up, center during MUTE_PRE, down during MUTE_POST
        set_keys(KU);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mute !== 1'b1 && lat < 40);
        check("pend latency", lat, 7);
        set_keys(KC);
        n = 0;
        while (freq_upd !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pend upd1_pos", n, 8);
        check("pend freq1", cw_freq, 32'd104000000);
        set_keys(KD);
        n = 0;
        while (mute === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pend post_len", n, 9);
        @(negedge clk);
        check("pend restart", {31'b0, mute}, 1);
        set_keys(5'b0);
        n = 0;
        while (freq_upd !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pend upd2_pos", n, 8);
        check("pend freq2", cw_freq, 32'd103950000);
        n = 0;
        while (mute === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        nupd = 0;
        repeat (30) begin
            @(negedge clk);
            if (freq_upd === 1'b1 || mute === 1'b1) nupd++;
        end
        check("pend no_third", nupd, 0);
        check("pend freq_final", cw_freq, 32'd103950000);

        // Reset during MUTE_PRE of a right press
        set_keys(KR);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mute !== 1'b1 && lat < 40);
        set_keys(5'b0);
        check("rstmid latency", lat, 7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid flags", {29'b0, freq_upd, mute, busy}, 0);
        check("rstmid freq", cw_freq, 32'd104000000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (freq_upd !== 1'b0 || mute !== 1'b0) n++;
        end
        check("rstmid quiet", n, 0);
        check("rstmid freq_after", cw_freq, 32'd104000000);

        // Held key: one step, or repeats when auto-repeat is built in
        set_keys(KU);
        nupd = 0;
        repeat (107) begin
            @(negedge clk);
            if (freq_upd === 1'b1) nupd++;
        end
        set_keys(5'b0);
        repeat (300) begin
            @(negedge clk);
            if (freq_upd === 1'b1) nupd++;
        end
        check("hold idle", {31'b0, busy}, 0);
`ifdef FM_TUNE_AUTOREPEAT_EN
        check("hold repeats", {31'b0, nupd >= 3}, 1);
        check("hold freq", cw_freq, 32'd104000000 + 32'(nupd) * 32'd50000);
`else
        check("hold upd_cnt", nupd, 1);
        check("hold freq", cw_freq, 32'd104050000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
